// File: rtl/uart_cfg_sequencer.sv
// UART bring-up sequencer: owns the UART register port while it disables the UART,
// loads line/FIFO/baud settings, optionally verifies them, and then re-enables it.
module uart_cfg_sequencer #(
  parameter logic [15:0] LCR_INIT  = 16'h0038,
  parameter logic [15:0] FCR_INIT  = 16'h0044,
  parameter logic [15:0] IBRD_INIT = 16'd26,
  parameter logic [15:0] FBRD_INIT = 16'd3,
  parameter logic [15:0] CR_INIT   = 16'h0007,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic        DSP_CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        DROP,
  input  logic        H_CEn,
  input  logic [4:1]  H_ADDR,
  input  logic [15:0] H_WDATA,
  input  logic        H_WEn,
  output logic [15:0] H_RDATA,
  output logic        U_CEn,
  output logic [4:1]  U_ADDR,
  output logic [15:0] U_WDATA,
  output logic        U_WEn,
  input  logic [15:0] U_RDATA
);

  localparam logic [4:1] ADDR_LCR  = 4'd1;
  localparam logic [4:1] ADDR_FCR  = 4'd2;
  localparam logic [4:1] ADDR_CR   = 4'd3;
  localparam logic [4:1] ADDR_IBRD = 4'd7;
  localparam logic [4:1] ADDR_FBRD = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE, S_DIS, S_WR, S_RD, S_CMP, S_EN, S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic        err_q, err_d;
  logic [4:1]  entry_addr;
  logic [15:0] entry_val;

  always_comb begin
    entry_addr = ADDR_LCR;
    entry_val  = LCR_INIT;
    case (k_q)
      2'd0: begin entry_addr = ADDR_LCR;  entry_val = LCR_INIT;  end
      2'd1: begin entry_addr = ADDR_FCR;  entry_val = FCR_INIT;  end
      2'd2: begin entry_addr = ADDR_IBRD; entry_val = IBRD_INIT; end
      default: begin entry_addr = ADDR_FBRD; entry_val = FBRD_INIT; end
    endcase
  end

  always_ff @(posedge DSP_CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      k_q     <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    err_d   = err_q;
    U_CEn   = 1'b1;
    U_WEn   = 1'b1;
    U_ADDR  = 4'd0;
    U_WDATA = 16'h0000;
    case (state_q)
      S_IDLE: begin
        // Host passthrough; a START here still lets this cycle's host access through.
        U_CEn   = H_CEn;
        U_WEn   = H_WEn;
        U_ADDR  = H_ADDR;
        U_WDATA = H_WDATA;
        if (START) begin
          state_d = S_DIS;
          k_d     = 2'd0;
          err_d   = 1'b0;
        end
      end
      S_DIS: begin
        U_CEn   = 1'b0;
        U_WEn   = 1'b0;
        U_ADDR  = ADDR_CR;
        U_WDATA = 16'h0000;
        state_d = S_WR;
      end
      S_WR: begin
        U_CEn   = 1'b0;
        U_WEn   = 1'b0;
        U_ADDR  = entry_addr;
        U_WDATA = entry_val;
        if (k_q == 2'd3) begin
          k_d     = 2'd0;
          state_d = VERIFY ? S_RD : S_EN;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_RD: begin
        U_CEn   = 1'b0;
        U_WEn   = 1'b1;
        U_ADDR  = entry_addr;
        state_d = S_CMP;
      end
      S_CMP: begin
        // Read data from the previous RD cycle is registered in the UART block.
        if (U_RDATA != entry_val) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else if (k_q == 2'd3) begin
          state_d = S_EN;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = S_RD;
        end
      end
      S_EN: begin
        U_CEn   = 1'b0;
        U_WEn   = 1'b0;
        U_ADDR  = ADDR_CR;
        U_WDATA = CR_INIT;
        state_d = S_FIN;
      end
      S_FIN: begin
        k_d     = 2'd0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign BUSY    = (state_q != S_IDLE);
  assign DONE    = (state_q == S_FIN);
  assign ERR     = err_q;
  assign DROP    = BUSY & ~H_CEn;
  assign H_RDATA = U_RDATA;

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Directed bench for uart_cfg_sequencer: a verifying and a non-verifying instance,
// each attached to a small UART register model with registered read data.
module tb_uart_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic        h_cen = 1'b1, h_wen = 1'b1;
  logic [3:0]  h_addr = 4'd0;
  logic [15:0] h_wdata = 16'h0000;
  logic        corrupt = 1'b0;

  logic        busy0, done0, err0, drop0, u_cen0, u_wen0;
  logic [3:0]  u_addr0;
  logic [15:0] u_wdata0, h_rdata0, rdata0;
  logic        busy1, done1, err1, drop1, u_cen1, u_wen1;
  logic [3:0]  u_addr1;
  logic [15:0] u_wdata1, h_rdata1, rdata1;

  logic [15:0] regs0 [0:15];
  logic [15:0] regs1 [0:15];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_cfg_sequencer dut0 (
    .DSP_CLK(clk), .RESET(rst), .START(start0), .BUSY(busy0), .DONE(done0), .ERR(err0),
    .DROP(drop0), .H_CEn(h_cen), .H_ADDR(h_addr), .H_WDATA(h_wdata), .H_WEn(h_wen),
    .H_RDATA(h_rdata0), .U_CEn(u_cen0), .U_ADDR(u_addr0), .U_WDATA(u_wdata0),
    .U_WEn(u_wen0), .U_RDATA(rdata0)
  );

  uart_cfg_sequencer #(.VERIFY(1'b0)) dut1 (
    .DSP_CLK(clk), .RESET(rst), .START(start1), .BUSY(busy1), .DONE(done1), .ERR(err1),
    .DROP(drop1), .H_CEn(h_cen), .H_ADDR(h_addr), .H_WDATA(h_wdata), .H_WEn(h_wen),
    .H_RDATA(h_rdata1), .U_CEn(u_cen1), .U_ADDR(u_addr1), .U_WDATA(u_wdata1),
    .U_WEn(u_wen1), .U_RDATA(rdata1)
  );

  // Register models; instance 0 can flip bit 0 of IBRD on read-back.
  always @(posedge clk) begin
    if (!u_cen0 && !u_wen0) regs0[u_addr0] <= u_wdata0;
    if (!u_cen0 && u_wen0)
      rdata0 <= (corrupt && u_addr0 == 4'd7) ? (regs0[u_addr0] ^ 16'h0001) : regs0[u_addr0];
    if (!u_cen1 && !u_wen1) regs1[u_addr1] <= u_wdata1;
    if (!u_cen1 && u_wen1) rdata1 <= regs1[u_addr1];
  end

  // Expected bus per cycle of a VERIFY=1 run: {cen, wen, addr, wdata}; index = cycle number.
  logic [21:0] exp_v1 [1:15];
  logic [21:0] exp_v0 [1:7];

  initial begin
    exp_v1[1]  = {1'b0, 1'b0, 4'd3, 16'h0000};
    exp_v1[2]  = {1'b0, 1'b0, 4'd1, 16'h0038};
    exp_v1[3]  = {1'b0, 1'b0, 4'd2, 16'h0044};
    exp_v1[4]  = {1'b0, 1'b0, 4'd7, 16'h001A};
    exp_v1[5]  = {1'b0, 1'b0, 4'd8, 16'h0003};
    exp_v1[6]  = {1'b0, 1'b1, 4'd1, 16'h0000};
    exp_v1[7]  = {1'b1, 1'b1, 4'd0, 16'h0000};
    exp_v1[8]  = {1'b0, 1'b1, 4'd2, 16'h0000};
    exp_v1[9]  = {1'b1, 1'b1, 4'd0, 16'h0000};
    exp_v1[10] = {1'b0, 1'b1, 4'd7, 16'h0000};
    exp_v1[11] = {1'b1, 1'b1, 4'd0, 16'h0000};
    exp_v1[12] = {1'b0, 1'b1, 4'd8, 16'h0000};
    exp_v1[13] = {1'b1, 1'b1, 4'd0, 16'h0000};
    exp_v1[14] = {1'b0, 1'b0, 4'd3, 16'h0007};
    exp_v1[15] = {1'b1, 1'b1, 4'd0, 16'h0000};
    exp_v0[1]  = {1'b0, 1'b0, 4'd3, 16'h0000};
    exp_v0[2]  = {1'b0, 1'b0, 4'd1, 16'h0038};
    exp_v0[3]  = {1'b0, 1'b0, 4'd2, 16'h0044};
    exp_v0[4]  = {1'b0, 1'b0, 4'd7, 16'h001A};
    exp_v0[5]  = {1'b0, 1'b0, 4'd8, 16'h0003};
    exp_v0[6]  = {1'b0, 1'b0, 4'd3, 16'h0007};
    exp_v0[7]  = {1'b1, 1'b1, 4'd0, 16'h0000};
  end

  // Pulse START on instance 0 for one edge; returns at the negedge of cycle 1.
  task automatic go0();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    h_cen = 1'b0; h_wen = 1'b1; h_addr = 4'd2; h_wdata = 16'h1234;
    #1;
    tests++;
    if ({busy0, done0, err0, drop0} !== 4'b0000) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {busy0, done0, err0, drop0});
    end
    tests++;
    if ({u_cen0, u_wen0, u_addr0, u_wdata0} !== {1'b0, 1'b1, 4'd2, 16'h1234}) begin
      fails++; $display("FAIL reset_passthru: got %b %b %h %h want 0 1 2 1234",
                        u_cen0, u_wen0, u_addr0, u_wdata0);
    end
    $display("[TB] reset checked");
    h_cen = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sequence();
    int c;
    corrupt = 1'b0;
    go0();
    for (c = 1; c <= 15; c++) begin
      tests++;
      if (exp_v1[c][21]) begin
        if (u_cen0 !== 1'b1) begin
          fails++; $display("FAIL seq_idle c%0d: cen=%b want 1", c, u_cen0);
        end
      end else if (exp_v1[c][20]) begin
        if ({u_cen0, u_wen0, u_addr0} !== exp_v1[c][21:16]) begin
          fails++; $display("FAIL seq_read c%0d: got %b %b %h want %b", c, u_cen0, u_wen0,
                            u_addr0, exp_v1[c][21:16]);
        end
      end else if ({u_cen0, u_wen0, u_addr0, u_wdata0} !== exp_v1[c]) begin
        fails++; $display("FAIL seq_write c%0d: got %b %b %h %h want %h", c, u_cen0, u_wen0,
                          u_addr0, u_wdata0, exp_v1[c]);
      end
      tests++;
      if ({busy0, done0} !== {1'b1, (c == 15)}) begin
        fails++; $display("FAIL seq_busy_done c%0d: got %b%b want 1%b", c, busy0, done0, c == 15);
      end
      @(negedge clk);
    end
    tests++;
    if ({busy0, done0, err0} !== 3'b000) begin
      fails++; $display("FAIL seq_end: busy/done/err=%b want 000", {busy0, done0, err0});
    end
    tests++;
    if (regs0[3] !== 16'h0007) begin
      fails++; $display("FAIL seq_cr: CR=%h want 0007", regs0[3]);
    end
    $display("[TB] verify sequence done, err=%b", err0);
  endtask

  task automatic test_mismatch();
    int c, n;
    corrupt = 1'b1;
    go0();
    for (c = 1; c < 11; c++) @(negedge clk);
    // Now in cycle 11 (CMP of IBRD)
    for (c = 11; c <= 13; c++) begin
      tests++;
      if (u_cen0 !== 1'b1) begin
        fails++; $display("FAIL mm_no_cr c%0d: cen=%b addr=%h want cen 1", c, u_cen0, u_addr0);
      end
      tests++;
      if (done0 !== (c == 12)) begin
        fails++; $display("FAIL mm_done c%0d: got %b want %b", c, done0, c == 12);
      end
      if (c >= 12) begin
        tests++;
        if (err0 !== 1'b1) begin
          fails++; $display("FAIL mm_err c%0d: got %b want 1", c, err0);
        end
      end
      @(negedge clk);
    end
    tests++;
    if (busy0 !== 1'b0) begin
      fails++; $display("FAIL mm_busy_end: got %b want 0", busy0);
    end
    $display("[TB] mismatch run done, err=%b", err0);
    corrupt = 1'b0;
    go0();
    tests++;
    if ({busy0, err0} !== 2'b10) begin
      fails++; $display("FAIL mm_err_clear: busy/err=%b want 10", {busy0, err0});
    end
    n = 0;
    while (!done0 && n < 40) begin @(negedge clk); n++; end
    tests++;
    if (!done0 || err0 !== 1'b0) begin
      fails++; $display("FAIL mm_rerun: done=%b err=%b want 1 0", done0, err0);
    end
    @(negedge clk);
  endtask

  task automatic test_noverify();
    int c;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (c = 1; c <= 7; c++) begin
      tests++;
      if (exp_v0[c][21]) begin
        if (u_cen1 !== 1'b1) begin
          fails++; $display("FAIL nv_idle c%0d: cen=%b want 1", c, u_cen1);
        end
      end else if ({u_cen1, u_wen1, u_addr1, u_wdata1} !== exp_v0[c]) begin
        fails++; $display("FAIL nv_write c%0d: got %b %b %h %h want %h", c, u_cen1, u_wen1,
                          u_addr1, u_wdata1, exp_v0[c]);
      end
      tests++;
      if ({busy1, done1} !== {1'b1, (c == 7)}) begin
        fails++; $display("FAIL nv_busy_done c%0d: got %b%b want 1%b", c, busy1, done1, c == 7);
      end
      @(negedge clk);
    end
    tests++;
    if (busy1 !== 1'b0) begin
      fails++; $display("FAIL nv_end: busy=%b want 0", busy1);
    end
    $display("[TB] no-verify sequence done");
  endtask

  task automatic test_drop();
    int n;
    go0();
    @(negedge clk);
    @(negedge clk);
    // Cycle 3: sequencer writes FCR; host tries CR
    h_cen = 1'b0; h_wen = 1'b0; h_addr = 4'd3; h_wdata = 16'hFFFF;
    #1;
    tests++;
    if (drop0 !== 1'b1) begin
      fails++; $display("FAIL drop_pulse: got %b want 1", drop0);
    end
    tests++;
    if ({u_cen0, u_wen0, u_addr0, u_wdata0} !== {1'b0, 1'b0, 4'd2, 16'h0044}) begin
      fails++; $display("FAIL drop_blocked: got %b %b %h %h want 0 0 2 0044",
                        u_cen0, u_wen0, u_addr0, u_wdata0);
    end
    @(negedge clk);
    h_cen = 1'b1;
    #1;
    tests++;
    if (drop0 !== 1'b0) begin
      fails++; $display("FAIL drop_clear: got %b want 0", drop0);
    end
    n = 0;
    while (!done0 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    // Idle: same host write plus START in the same cycle
    h_cen = 1'b0; h_wen = 1'b0; h_addr = 4'd3; h_wdata = 16'hFFFF; start0 = 1'b1;
    #1;
    tests++;
    if ({u_cen0, u_wen0, u_addr0, u_wdata0, drop0} !== {1'b0, 1'b0, 4'd3, 16'hFFFF, 1'b0}) begin
      fails++; $display("FAIL idle_fwd: got %b %b %h %h drop=%b want 0 0 3 ffff 0",
                        u_cen0, u_wen0, u_addr0, u_wdata0, drop0);
    end
    @(negedge clk);
    start0 = 1'b0; h_cen = 1'b1;
    tests++;
    if ({busy0, u_cen0, u_addr0, u_wdata0} !== {1'b1, 1'b0, 4'd3, 16'h0000}) begin
      fails++; $display("FAIL idle_start_next: got %b %b %h %h want 1 0 3 0000",
                        busy0, u_cen0, u_addr0, u_wdata0);
    end
    n = 0;
    while (!done0 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    $display("[TB] drop/forward checked");
  endtask

  task automatic test_back_to_back();
    int c, dones, busys;
    dones = 0; busys = 0;
    go0();
    for (c = 1; c <= 30; c++) begin
      if (c == 3 || c == 8 || c == 15) start0 = 1'b1; else start0 = 1'b0;
      dones += int'(done0);
      busys += int'(busy0);
      @(negedge clk);
    end
    start0 = 1'b0;
    tests++;
    if (dones != 1) begin
      fails++; $display("FAIL restart_done_count: got %0d want 1", dones);
    end
    tests++;
    if (busys != 15) begin
      fails++; $display("FAIL restart_busy_count: got %0d want 15", busys);
    end
    $display("[TB] restart ignored, dones=%0d busy=%0d", dones, busys);
  endtask

  task automatic test_reset_mid();
    int c, busys, done_at;
    go0();
    for (c = 1; c < 8; c++) @(negedge clk);
    h_cen = 1'b0; h_wen = 1'b1; h_addr = 4'd4; h_wdata = 16'hBEEF;
    rst = 1'b1;
    #1;
    tests++;
    if ({busy0, done0, err0, drop0} !== 4'b0000) begin
      fails++; $display("FAIL rstmid_flags: got %b want 0000", {busy0, done0, err0, drop0});
    end
    tests++;
    if ({u_cen0, u_wen0, u_addr0, u_wdata0} !== {1'b0, 1'b1, 4'd4, 16'hBEEF}) begin
      fails++; $display("FAIL rstmid_passthru: got %b %b %h %h want 0 1 4 beef",
                        u_cen0, u_wen0, u_addr0, u_wdata0);
    end
    @(negedge clk);
    rst = 1'b0; h_cen = 1'b1;
    @(negedge clk);
    go0();
    busys = 0; done_at = 0;
    for (c = 1; c <= 20; c++) begin
      busys += int'(busy0);
      if (done0 && done_at == 0) done_at = c;
      @(negedge clk);
    end
    tests++;
    if (busys != 15 || done_at != 15) begin
      fails++; $display("FAIL rstmid_rerun: busy=%0d done_at=%0d want 15 15", busys, done_at);
    end
    tests++;
    if (regs0[3] !== 16'h0007 || err0 !== 1'b0) begin
      fails++; $display("FAIL rstmid_cr: CR=%h err=%b want 0007 0", regs0[3], err0);
    end
    $display("[TB] mid-sequence reset checked");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequence();
    test_mismatch();
    test_noverify();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_cfg_sequencer.md
# uart_cfg_sequencer

- Sits between the DSP host bus and the UART register block's DSP port.
- On a START pulse it takes the register bus and performs a fixed bring-up sequence:
  - disables the UART;
  - writes LCR, FCR, IBRD and FBRD from parameters;
  - optionally reads them back and compares;
  - enables the UART through CR.
- When idle, host accesses pass straight through. While a sequence runs, host accesses are blocked and flagged.

## Interface

Parameters:
- LCR_INIT, 16'h0038: LCR value (8 data bits, FIFO enabled, no parity, 1 stop bit).
- FCR_INIT, 16'h0044: FCR value (Rx and Tx FIFO levels = 4).
- IBRD_INIT, 16'd26: integer baud divisor.
- FBRD_INIT, 16'd3: fractional baud divisor.
- CR_INIT, 16'h0007: final CR value (UARTEn, RxEn, TxEn).
- VERIFY, 1: 1 = read-back check enabled; 0 = skip it.

Ports:
- DSP_CLK, input, 1: single clock; all state updates on its rising edge.
- RESET, input, 1: asynchronous, active-high reset.
- START, input, 1: request to run the sequence; sampled only in IDLE.
- BUSY, output, 1: high while the sequencer owns the bus.
- DONE, output, 1: one-cycle pulse at sequence end (pass or fail).
- ERR, output, 1: sticky read-back mismatch flag; cleared by the next accepted START.
- DROP, output, 1: one-cycle pulse when a host access is blocked while BUSY.
- H_CEn, input, 1: host chip enable, active-low.
- H_ADDR, input, 4 ([4:1]): host register address.
- H_WDATA, input, 16: host write data.
- H_WEn, input, 1: host write enable, active-low (1 = read).
- H_RDATA, output, 16: host read data, always equal to U_RDATA.
- U_CEn, output, 1: chip enable to the UART register block.
- U_ADDR, output, 4 ([4:1]): address to the UART register block.
- U_WDATA, output, 16: write data to the UART register block.
- U_WEn, output, 1: write enable to the UART register block.
- U_RDATA, input, 16: registered read data from the UART register block; valid one cycle after a read cycle.

## Operation

- Register map: LCR=1, FCR=2, CR=3, FR=4, IBRD=7, FBRD=8. FR is never accessed by this block.
- Bus cycle encoding:
  - write: U_CEn=0, U_WEn=0;
  - read: U_CEn=0, U_WEn=1;
  - no access: U_CEn=1.
- Bus outputs are decoded combinationally from the state register (Moore). Each non-IDLE state is exactly one bus cycle.
- States:
  - IDLE: passthrough, U_* = H_*. On START=1, go to DIS and clear ERR.
  - DIS: write CR = 16'h0000 → WR.
  - WR: step index k = 0..3 selects (LCR, LCR_INIT), (FCR, FCR_INIT), (IBRD, IBRD_INIT), (FBRD, FBRD_INIT). Writes entry k.
    - k<3: k+1.
    - k=3: k=0, then RD if VERIFY=1, otherwise EN.
  - RD: read address of entry k → CMP.
  - CMP: U_CEn=1; compare U_RDATA with the entry-k value over all 16 bits.
    - Mismatch: set ERR, go to FIN. CR is not enabled.
    - Match, k<3: k+1, go to RD.
    - Match, k=3: go to EN.
  - EN: write CR = CR_INIT → FIN.
  - FIN: U_CEn=1, DONE=1 → IDLE.
- BUSY = (state ≠ IDLE).
- START is ignored while BUSY; no queuing.
- Host access during BUSY (H_CEn=0): not forwarded, DROP=1 that cycle, H_RDATA content undefined for it.
- START asserted in the same cycle as an idle host access: the host access is forwarded that cycle; the sequence starts next cycle.

## Timing

- Reset values: BUSY=0, DONE=0, ERR=0, DROP=0, state=IDLE, k=0. U_* mirror H_* during and after reset.
- START sampled at edge T → DIS bus cycle during T+1.
- VERIFY=1, all pass:
  - DIS at cycle 1, WR at cycles 2–5, RD/CMP pairs at cycles 6–13, EN at 14, FIN/DONE at 15;
  - BUSY high for 15 cycles.
- VERIFY=0: DIS at 1, WR at 2–5, EN at 6, DONE at 7.
- Mismatch on entry k: DONE occurs 2 cycles after that entry's RD cycle; there is no EN cycle.
- The read-to-compare gap is 1 cycle, matching the registered read data of the UART register block.
- ERR changes only at an accepted START (clear) or at a CMP mismatch (set).
- RESET mid-sequence: immediate return to IDLE, all flags 0. A partially written configuration remains in the UART register block.

## Test plan

- Defaults, VERIFY=1, ideal register model; START pulse → bus writes are:
  - 3←0000, 1←0038, 2←0044, 7←001A, 8←0003;
  - then reads 1, 2, 7, 8;
  - then 3←0007;
  - DONE at cycle 15, ERR=0, BUSY for 15 cycles.
- Model corrupts the IBRD read to 001B → ERR=1, DONE 2 cycles after the IBRD read, no CR write issued.
- VERIFY=0 → no read cycles, CR←0007 at cycle 6, DONE at cycle 7.
- Host write to address 3 during BUSY → DROP pulse, not visible on U_*. The same write while idle → forwarded unchanged in the same cycle.
- START re-pulsed while BUSY → no restart, single DONE.
- RESET asserted at cycle 8 → BUSY=0 immediately, U_* follow H_*; a following START runs the full sequence again.
